// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage and architectural register file.
// Commits valE/valM to R0..R14 and latches the final processor status.
module writeback_regfile #(
  parameter logic [63:0] RSP_INIT = 64'd256,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             Cnd,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [2:0]       stat,
  output logic [63:0]      R0,
  output logic [63:0]      R1,
  output logic [63:0]      R2,
  output logic [63:0]      R3,
  output logic [63:0]      R4,
  output logic [63:0]      R5,
  output logic [63:0]      R6,
  output logic [63:0]      R7,
  output logic [63:0]      R8,
  output logic [63:0]      R9,
  output logic [63:0]      R10,
  output logic [63:0]      R11,
  output logic [63:0]      R12,
  output logic [63:0]      R13,
  output logic [63:0]      R14,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP_ID   = 4'd4;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [63:0]       r_regs [15];
  logic [2:0]        r_final_stat;
  logic [CNT_W-1:0]  r_retired;
  logic [2:0]        w_eff_stat;
  logic              w_commit;
  logic              w_stop;

  // Destination register decode; cmovXX only targets rB when the condition holds.
  always_comb begin
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      I_RRMOVQ: begin
        if (Cnd) begin
          dstE = rB;
        end else begin
          dstE = RNONE;
        end
      end
      I_IRMOVQ, I_OPQ:                  dstE = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:   dstE = RSP_ID;
      default:                          dstE = RNONE;
    endcase
    case (icode)
      I_MRMOVQ, I_POPQ: dstM = rA;
      default:          dstM = RNONE;
    endcase
  end

  // A halt that fetched cleanly still stops the machine with HLT status.
  always_comb begin
    w_eff_stat = stat;
    if (icode == I_HALT && stat == STAT_AOK) begin
      w_eff_stat = STAT_HLT;
    end else begin
      w_eff_stat = stat;
    end
  end

  assign w_commit = (r_state == ST_RUN) && instr_valid && (w_eff_stat == STAT_AOK);
  assign w_stop   = (r_state == ST_RUN) && instr_valid && (w_eff_stat != STAT_AOK);

  // Next-state logic: STOP is sticky until reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_stop) begin
          w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_STOP: w_state_next = ST_STOP;
      default: w_state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Final status latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_final_stat <= STAT_AOK;
    end else if (w_stop) begin
      r_final_stat <= w_eff_stat;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Register file write; valM is checked first so it wins on dstE == dstM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 15; i++) begin
      if (reset) begin
        r_regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
      end else if (w_commit && dstM == 4'(i)) begin
        r_regs[i] <= valM;
      end else if (w_commit && dstE == 4'(i)) begin
        r_regs[i] <= valE;
      end
    end
  end

  assign R0         = r_regs[0];
  assign R1         = r_regs[1];
  assign R2         = r_regs[2];
  assign R3         = r_regs[3];
  assign R4         = r_regs[4];
  assign R5         = r_regs[5];
  assign R6         = r_regs[6];
  assign R7         = r_regs[7];
  assign R8         = r_regs[8];
  assign R9         = r_regs[9];
  assign R10        = r_regs[10];
  assign R11        = r_regs[11];
  assign R12        = r_regs[12];
  assign R13        = r_regs[13];
  assign R14        = r_regs[14];
  assign halted     = (r_state == ST_STOP);
  assign final_stat = r_final_stat;
  assign retired    = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: the driver queues hand-computed
// expectations per cycle, a monitor checks them one edge later.
module tb_writeback_regfile;

  localparam logic [3:0]  RN   = 4'hF;
  localparam int          NONE = 15;
  localparam logic [63:0] DEAD = 64'hDEAD;

  logic        clk = 1'b0;
  logic        reset, instr_valid, Cnd;
  logic [3:0]  icode, rA, rB;
  logic [63:0] valE, valM;
  logic [2:0]  stat;
  logic [63:0] rv [15];
  logic [3:0]  dstE, dstM;
  logic        halted;
  logic [2:0]  final_stat;
  logic [1:0]  retired;

  always #5 clk = ~clk;

  writeback_regfile #(.RSP_INIT(64'd256), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .icode(icode),
    .rA(rA), .rB(rB), .Cnd(Cnd), .valE(valE), .valM(valM), .stat(stat),
    .R0(rv[0]), .R1(rv[1]), .R2(rv[2]), .R3(rv[3]), .R4(rv[4]),
    .R5(rv[5]), .R6(rv[6]), .R7(rv[7]), .R8(rv[8]), .R9(rv[9]),
    .R10(rv[10]), .R11(rv[11]), .R12(rv[12]), .R13(rv[13]), .R14(rv[14]),
    .dstE(dstE), .dstM(dstM), .halted(halted), .final_stat(final_stat),
    .retired(retired)
  );

  typedef struct {
    logic [3:0]  e_dste;
    logic [3:0]  e_dstm;
    logic        all_rst;
    int          c1_idx;
    logic [63:0] c1_val;
    int          c2_idx;
    logic [63:0] c2_val;
    logic        e_halted;
    logic [2:0]  e_fstat;
    logic [1:0]  e_ret;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, ".dstE"}, 64'(dstE), 64'(mon_e.e_dste));
        check({mon_e.tag, ".dstM"}, 64'(dstM), 64'(mon_e.e_dstm));
        check({mon_e.tag, ".halted"}, 64'(halted), 64'(mon_e.e_halted));
        check({mon_e.tag, ".final_stat"}, 64'(final_stat), 64'(mon_e.e_fstat));
        check({mon_e.tag, ".retired"}, 64'(retired), 64'(mon_e.e_ret));
        if (mon_e.all_rst) begin
          for (int i = 0; i < 15; i++) begin
            check($sformatf("%s.R%0d", mon_e.tag, i), rv[i], (i == 4) ? 64'd256 : 64'd0);
          end
        end
        if (mon_e.c1_idx < 15) begin
          check($sformatf("%s.R%0d", mon_e.tag, mon_e.c1_idx), rv[mon_e.c1_idx], mon_e.c1_val);
        end
        if (mon_e.c2_idx < 15) begin
          check($sformatf("%s.R%0d", mon_e.tag, mon_e.c2_idx), rv[mon_e.c2_idx], mon_e.c2_val);
        end
      end
    end
  end

  task automatic step(
    input logic rst, input logic v, input logic [3:0] ic, input logic [3:0] a,
    input logic [3:0] b, input logic c, input logic [63:0] ve, input logic [63:0] vm,
    input logic [2:0] st, input logic [3:0] xe, input logic [3:0] xm, input logic xr,
    input int i1, input logic [63:0] v1, input int i2, input logic [63:0] v2,
    input logic xh, input logic [2:0] xf, input logic [1:0] xret, input string tag);
    exp_t x;
    @(negedge clk);
    reset = rst; instr_valid = v; icode = ic; rA = a; rB = b; Cnd = c;
    valE = ve; valM = vm; stat = st;
    x.e_dste = xe; x.e_dstm = xm; x.all_rst = xr;
    x.c1_idx = i1; x.c1_val = v1; x.c2_idx = i2; x.c2_val = v2;
    x.e_halted = xh; x.e_fstat = xf; x.e_ret = xret; x.tag = tag;
    sb_q.push_back(x);
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; icode = 4'h1; rA = RN; rB = RN;
    Cnd = 1'b0; valE = 64'd0; valM = 64'd0; stat = 3'd1;

    // reset beats a simultaneous irmovq
    step(1'b1, 1'b1, 4'h3, RN, 4'd2, 1'b0, 64'd99, 64'd0, 3'd1, 4'd2, RN, 1'b1, NONE, 64'd0, NONE, 64'd0, 1'b0, 3'd1, 2'd0, "reset_busy");
    step(1'b0, 1'b1, 4'h3, RN, 4'd2, 1'b0, 64'd7, 64'd0, 3'd1, 4'd2, RN, 1'b0, 2, 64'd7, 4, 64'd256, 1'b0, 3'd1, 2'd1, "irmovq");
    step(1'b0, 1'b1, 4'h6, 4'd0, 4'd2, 1'b0, 64'd12, 64'd0, 3'd1, 4'd2, RN, 1'b0, 2, 64'd12, 0, 64'd0, 1'b0, 3'd1, 2'd2, "opq");
    step(1'b0, 1'b1, 4'h2, 4'd1, 4'd7, 1'b0, 64'd5, 64'd0, 3'd1, RN, RN, 1'b0, 7, 64'd0, 2, 64'd12, 1'b0, 3'd1, 2'd3, "cmov_nt");
    step(1'b0, 1'b1, 4'h2, 4'd1, 4'd7, 1'b1, 64'd5, 64'd0, 3'd1, 4'd7, RN, 1'b0, 7, 64'd5, 1, 64'd0, 1'b0, 3'd1, 2'd0, "cmov_t");
    step(1'b0, 1'b1, 4'h8, RN, RN, 1'b0, 64'd248, 64'd0, 3'd1, 4'd4, RN, 1'b0, 4, 64'd248, 7, 64'd5, 1'b0, 3'd1, 2'd1, "call");
    step(1'b0, 1'b1, 4'hB, 4'd4, RN, 1'b0, 64'd256, DEAD, 3'd1, 4'd4, 4'd4, 1'b0, 4, DEAD, NONE, 64'd0, 1'b0, 3'd1, 2'd2, "popq_rsp");
    step(1'b0, 1'b1, 4'h5, 4'd3, RN, 1'b0, 64'd1000, 64'd42, 3'd1, RN, 4'd3, 1'b0, 3, 64'd42, 4, DEAD, 1'b0, 3'd1, 2'd3, "mrmovq");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 4'h3, RN, 4'd1, 1'b0, 64'd77, 64'd0, 3'd1, 4'd1, RN, 1'b0, 1, 64'd0, 3, 64'd42, 1'b0, 3'd1, 2'd3, "idle");
    end
    step(1'b0, 1'b1, 4'h3, RN, RN, 1'b0, 64'd55, 64'd0, 3'd1, RN, RN, 1'b0, 14, 64'd0, 2, 64'd12, 1'b0, 3'd1, 2'd0, "rnone");
    step(1'b0, 1'b1, 4'h0, RN, RN, 1'b0, 64'd0, 64'd0, 3'd1, RN, RN, 1'b0, 2, 64'd12, 4, DEAD, 1'b1, 3'd2, 2'd0, "halt");
    step(1'b0, 1'b1, 4'h3, RN, 4'd1, 1'b0, 64'd9, 64'd0, 3'd1, 4'd1, RN, 1'b0, 1, 64'd0, 2, 64'd12, 1'b1, 3'd2, 2'd0, "stopped");
    step(1'b1, 1'b0, 4'h0, RN, RN, 1'b0, 64'd0, 64'd0, 3'd1, RN, RN, 1'b1, NONE, 64'd0, NONE, 64'd0, 1'b0, 3'd1, 2'd0, "reset_halted");
    step(1'b0, 1'b1, 4'h5, 4'd3, RN, 1'b0, 64'd0, 64'd77, 3'd3, RN, 4'd3, 1'b0, 3, 64'd0, 4, 64'd256, 1'b1, 3'd3, 2'd0, "adr_fault");
    step(1'b1, 1'b0, 4'h0, RN, RN, 1'b0, 64'd0, 64'd0, 3'd1, RN, RN, 1'b1, NONE, 64'd0, NONE, 64'd0, 1'b0, 3'd1, 2'd0, "reset_fault");
    // five commits with a 2-bit counter: 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 4'h3, RN, 4'd5, 1'b0, 64'(k + 1), 64'd0, 3'd1, 4'd5, RN, 1'b0, 5, 64'(k + 1), NONE, 64'd0, 1'b0, 3'd1, 2'((k + 1) % 4), "count");
    end
    @(negedge clk);
    instr_valid = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
